// File: rtl/matrix_mult_nxn_seq_pkg.sv
// Shared state type and sizing/packing helpers for the sequential NxN matrix multiplier.
package mm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_e;

   // Accumulator wide enough to hold a sum of n full-width products without overflow.
   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
      return 2 * dw + $clog2(n);
   endfunction

   // Bit offset of element (i,j) in a row-major vector whose (0,0) sits in the MSBs.
   function automatic int unsigned elem_lsb(input int unsigned n, input int unsigned dw,
                                            input int unsigned i, input int unsigned j);
      return (n * n - 1 - (i * n + j)) * dw;
   endfunction

endpackage

// File: rtl/matrix_mult_nxn_seq_if.sv
// Request/response bundle between a requester and the matrix multiplier.
interface matrix_mult_nxn_seq_if #(
   parameter int unsigned N  = 3,
   parameter int unsigned DW = 8
);
   localparam int unsigned MW = N * N * DW;

   logic          start;
   logic          signed_mode;
   logic [MW-1:0] matrix_a;
   logic [MW-1:0] matrix_b;
   logic [MW-1:0] result;
   logic          valid_out;
   logic          busy;
   logic          overflow;

   modport master (
      output start, signed_mode, matrix_a, matrix_b,
      input  result, valid_out, busy, overflow
   );

   modport slave (
      input  start, signed_mode, matrix_a, matrix_b,
      output result, valid_out, busy, overflow
   );
endinterface

// File: rtl/matrix_mult_nxn_seq_lane.sv
// One result column lane: signed/unsigned multiply-accumulate with wrap or saturate conversion.
module mm_mac_lane
   import mm_pkg::*;
#(
   parameter int unsigned DW  = 8,
   parameter int unsigned AW  = 18,
   parameter int unsigned SAT = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic          last_i,
   input  logic          signed_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] elem_c_o,
   output logic          ovf_c_o
);

   localparam int unsigned XW = AW - DW;

   logic [AW-1:0] acc_q, acc_d;
   logic [AW-1:0] a_ext, b_ext, prod, sum, low_ext;
   logic [DW-1:0] low;

   // Sum including the current product drives both the accumulator and the row conversion.
   always_comb begin
      a_ext   = signed_i ? {{XW{a_i[DW-1]}}, a_i} : {{XW{1'b0}}, a_i};
      b_ext   = signed_i ? {{XW{b_i[DW-1]}}, b_i} : {{XW{1'b0}}, b_i};
      prod    = a_ext * b_ext;
      sum     = acc_q + prod;
      low     = sum[DW-1:0];
      low_ext = signed_i ? {{XW{low[DW-1]}}, low} : {{XW{1'b0}}, low};

      // Out of range exactly when the kept bits no longer re-extend to the full sum.
      ovf_c_o  = (sum != low_ext);
      elem_c_o = low;
      if ((SAT != 0) && ovf_c_o) begin
         if (!signed_i) begin
            elem_c_o = '1;
         end else if (sum[AW-1]) begin
            elem_c_o = {1'b1, {(DW-1){1'b0}}};
         end else begin
            elem_c_o = {1'b0, {(DW-1){1'b1}}};
         end
      end

      acc_d = acc_q;
      if (en_i) begin
         acc_d = last_i ? '0 : sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/matrix_mult_nxn_seq.sv
// Sequential NxN matrix multiplier: one k-step per cycle across N column lanes, one row per N cycles.
module matrix_mult_nxn_seq
   import mm_pkg::*;
#(
   parameter int unsigned N   = 3,
   parameter int unsigned DW  = 8,
   parameter int unsigned SAT = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   matrix_mult_nxn_seq_if.slave   mm_io
);

   localparam int unsigned   MW       = N * N * DW;
   localparam int unsigned   AW       = acc_width(DW, N);
   localparam int unsigned   CW       = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] r_q, r_d;
   logic [CW-1:0] k_q, k_d;
   logic [MW-1:0] a_q, a_d;
   logic [MW-1:0] b_q, b_d;
   logic [MW-1:0] res_q, res_d;
   logic          sgn_q, sgn_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;

   logic          lane_en;
   logic          lane_last;
   logic [DW-1:0] a_rk;
   logic [DW-1:0] b_kj  [N];
   logic [DW-1:0] elem  [N];
   logic [N-1:0]  lane_ovf;

   // A[r][k] is broadcast to every lane; lane j receives B[k][j].
   always_comb begin
      a_rk = a_q[elem_lsb(N, DW, 32'(r_q), 32'(k_q)) +: DW];
      for (int unsigned j = 0; j < N; j++) begin
         b_kj[j] = b_q[elem_lsb(N, DW, 32'(k_q), j) +: DW];
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_lane
      mm_mac_lane #(
         .DW  (DW),
         .AW  (AW),
         .SAT (SAT)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en_i     (lane_en),
         .last_i   (lane_last),
         .signed_i (sgn_q),
         .a_i      (a_rk),
         .b_i      (b_kj[j]),
         .elem_c_o (elem[j]),
         .ovf_c_o  (lane_ovf[j])
      );
   end

   // Controller: accept in IDLE, step k then r in CALC, write a result row on each last k.
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      k_d       = k_q;
      a_d       = a_q;
      b_d       = b_q;
      sgn_d     = sgn_q;
      res_d     = res_q;
      ovf_d     = ovf_q;
      valid_d   = 1'b0;
      lane_en   = 1'b0;
      lane_last = 1'b0;

      case (state_q)
         IDLE: begin
            if (mm_io.start) begin
               state_d = CALC;
               a_d     = mm_io.matrix_a;
               b_d     = mm_io.matrix_b;
               sgn_d   = mm_io.signed_mode;
               ovf_d   = 1'b0;
               r_d     = '0;
               k_d     = '0;
            end
         end
         CALC: begin
            lane_en   = 1'b1;
            lane_last = (k_q == CNT_LAST);
            if (lane_last) begin
               for (int unsigned j = 0; j < N; j++) begin
                  res_d[elem_lsb(N, DW, 32'(r_q), j) +: DW] = elem[j];
               end
               ovf_d = ovf_q | (|lane_ovf);
               k_d   = '0;
               if (r_q == CNT_LAST) begin
                  state_d = IDLE;
                  r_d     = '0;
                  valid_d = 1'b1;
               end else begin
                  r_d = r_q + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CALC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sgn_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sgn_q   <= sgn_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign mm_io.result    = res_q;
   assign mm_io.valid_out = valid_q;
   assign mm_io.busy      = busy_q;
   assign mm_io.overflow  = ovf_q;

endmodule

// File: tb/tb_matrix_mult_nxn_seq.sv
// Directed bench for matrix_mult_nxn_seq: a wrapping and a saturating instance driven in lockstep.
module tb_matrix_mult_nxn_seq;

   localparam int unsigned N  = 3;
   localparam int unsigned DW = 8;
   localparam int unsigned MW = N * N * DW;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   matrix_mult_nxn_seq_if #(.N(N), .DW(DW)) io0 ();
   matrix_mult_nxn_seq_if #(.N(N), .DW(DW)) io1 ();

   matrix_mult_nxn_seq #(.N(N), .DW(DW), .SAT(0)) dut0 (.clk(clk), .rst(rst), .mm_io(io0));
   matrix_mult_nxn_seq #(.N(N), .DW(DW), .SAT(1)) dut1 (.clk(clk), .rst(rst), .mm_io(io1));

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   function automatic logic [MW-1:0] pk9(input int e0, input int e1, input int e2,
                                         input int e3, input int e4, input int e5,
                                         input int e6, input int e7, input int e8);
      return {DW'(e0), DW'(e1), DW'(e2), DW'(e3), DW'(e4), DW'(e5), DW'(e6), DW'(e7), DW'(e8)};
   endfunction

   function automatic logic [MW-1:0] all9(input int e);
      return pk9(e, e, e, e, e, e, e, e, e);
   endfunction

   task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic sg, input logic [MW-1:0] a,
                        input logic [MW-1:0] b);
      io0.start = st; io0.signed_mode = sg; io0.matrix_a = a; io0.matrix_b = b;
      io1.start = st; io1.signed_mode = sg; io1.matrix_a = a; io1.matrix_b = b;
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic accept(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic sg);
      drive(1'b1, sg, a, b);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, sg, a, b);
   endtask

   task automatic wait_valid(input string tag);
      int lat;
      lat = 0;
      chk({tag, "_busy_calc"}, MW'(io0.busy), MW'(1));
      while (io0.valid_out !== 1'b1 && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, MW'(lat), MW'(9));
   endtask

   task automatic check_res(input string tag, input logic [MW-1:0] e0, input logic o0,
                            input logic [MW-1:0] e1, input logic o1);
      chk({tag, "_res_wrap"}, io0.result, e0);
      chk({tag, "_ovf_wrap"}, MW'(io0.overflow), MW'(o0));
      chk({tag, "_res_sat"},  io1.result, e1);
      chk({tag, "_ovf_sat"},  MW'(io1.overflow), MW'(o1));
      chk({tag, "_busy_done"}, MW'({io0.busy, io1.busy}), MW'(0));
   endtask

   task automatic run_op(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic sg, input logic [MW-1:0] e0, input logic o0,
                         input logic [MW-1:0] e1, input logic o1);
      accept(a, b, sg);
      wait_valid(tag);
      check_res(tag, e0, o0, e1, o1);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_pulse"}, MW'({io0.valid_out, io1.valid_out}), MW'(0));
   endtask

   logic [MW-1:0] a_seq, b_rev, ident, exp_basic, a_sgn, cap;
   int            cnt, pulses, vcyc;

   initial begin
      a_seq     = pk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
      b_rev     = pk9(9, 8, 7, 6, 5, 4, 3, 2, 1);
      ident     = pk9(1, 0, 0, 0, 1, 0, 0, 0, 1);
      exp_basic = pk9(30, 24, 18, 84, 69, 54, 138, 114, 90);
      a_sgn     = pk9(-1, 2, -3, 4, -5, 6, -7, 8, -9);

      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      chk("reset_result", io0.result | io1.result, '0);
      chk("reset_flags", MW'({io0.valid_out, io0.busy, io0.overflow,
                              io1.valid_out, io1.busy, io1.overflow}), MW'(0));
      rst = 1'b0;
      @(negedge clk);

      run_op("basic", a_seq, b_rev, 1'b0, exp_basic, 1'b0, exp_basic, 1'b0);
      run_op("ident", ident, b_rev, 1'b0, b_rev, 1'b0, b_rev, 1'b0);
      run_op("zero", '0, b_rev, 1'b0, '0, 1'b0, '0, 1'b0);
      run_op("u255", all9(255), all9(255), 1'b0, all9(3), 1'b1, all9(255), 1'b1);
      run_op("s128", all9(-128), all9(-128), 1'b1, all9(0), 1'b1, all9(127), 1'b1);
      run_op("sneg", all9(-128), all9(127), 1'b1, all9(128), 1'b1, all9(128), 1'b1);
      run_op("sid", a_sgn, ident, 1'b1, a_sgn, 1'b0, a_sgn, 1'b0);

      // Start pulses and operand changes mid-operation must not disturb the running product.
      accept(a_seq, b_rev, 1'b0);
      cnt = 0; pulses = 0; vcyc = -1; cap = '0;
      repeat (24) begin
         drive((cnt >= 2 && cnt <= 5), 1'b1, all9(7), all9(5));
         @(posedge clk);
         @(negedge clk);
         cnt++;
         if (io0.valid_out === 1'b1) begin
            pulses++;
            vcyc = cnt;
            cap  = io0.result;
         end
      end
      chk("ignore_pulses", MW'(pulses), MW'(1));
      chk("ignore_cycle", MW'(vcyc), MW'(9));
      chk("ignore_result", cap, exp_basic);
      chk("ignore_ovf", MW'(io0.overflow), MW'(0));

      // Reset during CALC aborts without a valid pulse and clears every output.
      accept(a_seq, b_rev, 1'b0);
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      #1;
      chk("abort_result", io0.result | io1.result, '0);
      chk("abort_flags", MW'({io0.valid_out, io0.busy, io0.overflow,
                              io1.valid_out, io1.busy, io1.overflow}), MW'(0));
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (15) begin
         @(posedge clk);
         @(negedge clk);
         if (io0.valid_out === 1'b1 || io1.valid_out === 1'b1) pulses++;
      end
      chk("abort_no_valid", MW'(pulses), MW'(0));
      run_op("after_rst", a_seq, b_rev, 1'b0, exp_basic, 1'b0, exp_basic, 1'b0);

      // Start held in the valid cycle launches the next operation with no bubble.
      accept(ident, b_rev, 1'b0);
      wait_valid("b2b_first");
      check_res("b2b_first", b_rev, 1'b0, b_rev, 1'b0);
      accept(a_seq, b_rev, 1'b0);
      wait_valid("b2b_second");
      check_res("b2b_second", exp_basic, 1'b0, exp_basic, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
